segre_pipeline_ctrl: RTL and testbench

Pipeline hazard controller for the Segre core. It watches the ID-stage source register identifiers, the EX-stage destination and load information, the EX branch resolution and the data-memory handshake. From these it drives the block and NOP-injection controls of the IF, ID, EX and MEM pipeline registers. It keeps a small state machine for multi-cycle load-use and memory-wait stalls, plus two saturating performance counters.

---
 rtl/segre_pkg.sv | 13 +
 rtl/segre_sat_counter.sv | 21 ++
 rtl/segre_pipeline_ctrl.sv | 135 +++++++++++++
 tb/tb_segre_pipeline_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/segre_pkg.sv
// Shared types and sizes for the Segre core pipeline control logic.
package segre_pkg;

   localparam int unsigned REG_SIZE = 5;
   localparam int unsigned LU_CNT_W = 3;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      MEM_WAIT = 2'd2
   } ctrl_state_e;

endpackage

// File: rtl/segre_sat_counter.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module segre_sat_counter (
   input  logic        clk_i,
   input  logic        rsn_i,
   input  logic        inc_i,
   output logic [31:0] count_o
);

   logic [31:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (!rsn_i) begin
         cnt_q <= '0;
      end else if (inc_i && (cnt_q != 32'hFFFF_FFFF)) begin
         cnt_q <= cnt_q + 32'd1;
      end
   end

   assign count_o = cnt_q;

endmodule

// File: rtl/segre_pipeline_ctrl.sv
// Hazard controller: load-use stalls, memory-wait holds and branch flushes
// for the IF/ID/EX/MEM pipeline registers, plus stall/flush counters.
module segre_pipeline_ctrl
   import segre_pkg::*;
#(
   parameter int unsigned LOAD_USE_BUBBLES = 1
) (
   input  logic                clk_i,
   input  logic                rsn_i,
   input  logic                id_valid_i,
   input  logic [REG_SIZE-1:0] id_src_a_i,
   input  logic [REG_SIZE-1:0] id_src_b_i,
   input  logic                ex_valid_i,
   input  logic                ex_rf_we_i,
   input  logic [REG_SIZE-1:0] ex_rf_waddr_i,
   input  logic                ex_memop_rd_i,
   input  logic                br_taken_i,
   input  logic                dmem_req_i,
   input  logic                dmem_ready_i,
   output logic                block_if_o,
   output logic                block_id_o,
   output logic                inject_nops_id_o,
   output logic                inject_nops_ex_o,
   output logic                block_ex_o,
   output logic                block_mem_o,
   output logic [31:0]         stall_cycles_o,
   output logic [31:0]         flush_count_o
);

   localparam logic [LU_CNT_W-1:0] LU_FULL = 3'(LOAD_USE_BUBBLES);

   ctrl_state_e         state_q, state_d;
   ctrl_state_e         ret_q, ret_d;
   logic [LU_CNT_W-1:0] lu_cnt_q, lu_cnt_d;

   logic lu_hazard, mem_wait, branch;
   logic hold_all, stall_lu, flush;

   assign lu_hazard = id_valid_i & ex_valid_i & ex_memop_rd_i & ex_rf_we_i
                    & (ex_rf_waddr_i != '0)
                    & ((ex_rf_waddr_i == id_src_a_i) | (ex_rf_waddr_i == id_src_b_i));
   assign mem_wait  = dmem_req_i & ~dmem_ready_i;
   assign branch    = br_taken_i & ex_valid_i;

   // lu_cnt_q counts the LU bubbles still owed, including the current one
   always_comb begin
      state_d  = state_q;
      ret_d    = ret_q;
      lu_cnt_d = lu_cnt_q;
      hold_all = 1'b0;
      stall_lu = 1'b0;
      flush    = 1'b0;
      if (mem_wait) begin
         hold_all = 1'b1;
         state_d  = MEM_WAIT;
         if (state_q == RUN) begin
            if (lu_hazard) begin
               ret_d    = LU_STALL;
               lu_cnt_d = LU_FULL;
            end else begin
               ret_d = RUN;
            end
         end else if (state_q == LU_STALL) begin
            ret_d = LU_STALL;
         end
      end else if (branch) begin
         // dependent instruction is on the wrong path, so any stall is dropped
         flush    = 1'b1;
         state_d  = RUN;
         ret_d    = RUN;
         lu_cnt_d = '0;
      end else begin
         unique case (state_q)
            RUN: begin
               if (lu_hazard) begin
                  stall_lu = 1'b1;
                  if (LOAD_USE_BUBBLES > 1) begin
                     lu_cnt_d = LU_FULL - 3'd1;
                     state_d  = LU_STALL;
                  end
               end
            end
            LU_STALL: begin
               stall_lu = 1'b1;
               lu_cnt_d = lu_cnt_q - 3'd1;
               if (lu_cnt_q == 3'd1) state_d = RUN;
            end
            MEM_WAIT: begin
               state_d = ret_q;
               ret_d   = RUN;
               if (ret_q == LU_STALL) begin
                  stall_lu = 1'b1;
                  lu_cnt_d = lu_cnt_q - 3'd1;
                  if (lu_cnt_q == 3'd1) state_d = RUN;
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rsn_i) begin
         state_q  <= RUN;
         ret_q    <= RUN;
         lu_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         ret_q    <= ret_d;
         lu_cnt_q <= lu_cnt_d;
      end
   end

   assign block_if_o       = rsn_i & (hold_all | stall_lu);
   assign block_id_o       = rsn_i & (hold_all | stall_lu);
   assign inject_nops_id_o = rsn_i & flush;
   assign inject_nops_ex_o = rsn_i & (flush | stall_lu);
   assign block_ex_o       = rsn_i & hold_all;
   assign block_mem_o      = rsn_i & hold_all;

   segre_sat_counter u_stall_cnt (
      .clk_i   (clk_i),
      .rsn_i   (rsn_i),
      .inc_i   (block_id_o),
      .count_o (stall_cycles_o)
   );

   segre_sat_counter u_flush_cnt (
      .clk_i   (clk_i),
      .rsn_i   (rsn_i),
      .inc_i   (inject_nops_id_o),
      .count_o (flush_count_o)
   );

endmodule

// File: tb/tb_segre_pipeline_ctrl.sv
// Bench for segre_pipeline_ctrl: two instances (1 and 3 load-use bubbles)
// share one input stream; directed scenarios plus a random run against a model.
module tb_segre_pipeline_ctrl;
   import segre_pkg::*;

   typedef struct packed {
      logic                rsn;
      logic                idv;
      logic [REG_SIZE-1:0] sa;
      logic [REG_SIZE-1:0] sb;
      logic                exv;
      logic                we;
      logic [REG_SIZE-1:0] wa;
      logic                rd;
      logic                br;
      logic                req;
      logic                rdy;
   } stim_t;

   logic clk = 1'b0;
   logic rsn_i = 1'b0, id_valid_i = 1'b0, ex_valid_i = 1'b0, ex_rf_we_i = 1'b0;
   logic ex_memop_rd_i = 1'b0, br_taken_i = 1'b0, dmem_req_i = 1'b0, dmem_ready_i = 1'b0;
   logic [REG_SIZE-1:0] id_src_a_i = '0, id_src_b_i = '0, ex_rf_waddr_i = '0;

   logic o1_bif, o1_bid, o1_iid, o1_iex, o1_bex, o1_bmem;
   logic o3_bif, o3_bid, o3_iid, o3_iex, o3_bex, o3_bmem;
   logic [31:0] stall1, flush1, stall3, flush3;
   logic [5:0]  out1, out3;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   segre_pipeline_ctrl #(.LOAD_USE_BUBBLES(1)) d1 (
      .clk_i(clk), .rsn_i(rsn_i), .id_valid_i(id_valid_i), .id_src_a_i(id_src_a_i),
      .id_src_b_i(id_src_b_i), .ex_valid_i(ex_valid_i), .ex_rf_we_i(ex_rf_we_i),
      .ex_rf_waddr_i(ex_rf_waddr_i), .ex_memop_rd_i(ex_memop_rd_i), .br_taken_i(br_taken_i),
      .dmem_req_i(dmem_req_i), .dmem_ready_i(dmem_ready_i), .block_if_o(o1_bif),
      .block_id_o(o1_bid), .inject_nops_id_o(o1_iid), .inject_nops_ex_o(o1_iex),
      .block_ex_o(o1_bex), .block_mem_o(o1_bmem), .stall_cycles_o(stall1),
      .flush_count_o(flush1)
   );

   segre_pipeline_ctrl #(.LOAD_USE_BUBBLES(3)) d3 (
      .clk_i(clk), .rsn_i(rsn_i), .id_valid_i(id_valid_i), .id_src_a_i(id_src_a_i),
      .id_src_b_i(id_src_b_i), .ex_valid_i(ex_valid_i), .ex_rf_we_i(ex_rf_we_i),
      .ex_rf_waddr_i(ex_rf_waddr_i), .ex_memop_rd_i(ex_memop_rd_i), .br_taken_i(br_taken_i),
      .dmem_req_i(dmem_req_i), .dmem_ready_i(dmem_ready_i), .block_if_o(o3_bif),
      .block_id_o(o3_bid), .inject_nops_id_o(o3_iid), .inject_nops_ex_o(o3_iex),
      .block_ex_o(o3_bex), .block_mem_o(o3_bmem), .stall_cycles_o(stall3),
      .flush_count_o(flush3)
   );

   // output vectors ordered {block_if, block_id, inject_id, inject_ex, block_ex, block_mem}
   assign out1 = {o1_bif, o1_bid, o1_iid, o1_iex, o1_bex, o1_bmem};
   assign out3 = {o3_bif, o3_bid, o3_iid, o3_iex, o3_bex, o3_bmem};

   localparam logic [5:0] OUT_IDLE  = 6'b000000;
   localparam logic [5:0] OUT_STALL = 6'b110100;
   localparam logic [5:0] OUT_HOLD  = 6'b110011;
   localparam logic [5:0] OUT_FLUSH = 6'b001100;

   function automatic stim_t idle();
      stim_t s = '0;
      s.rsn = 1'b1;
      return s;
   endfunction

   // EX holds a load to x5, ID reads x5 on rs1
   function automatic stim_t hazard();
      stim_t s = idle();
      s.idv = 1'b1; s.sa = 5'd5; s.sb = 5'd7;
      s.exv = 1'b1; s.we = 1'b1; s.wa = 5'd5; s.rd = 1'b1;
      return s;
   endfunction

   function automatic stim_t memwait();
      stim_t s = idle();
      s.req = 1'b1; s.rdy = 1'b0;
      return s;
   endfunction

   task automatic step(input stim_t s);
      @(posedge clk);
      #1;
      rsn_i = s.rsn; id_valid_i = s.idv; id_src_a_i = s.sa; id_src_b_i = s.sb;
      ex_valid_i = s.exv; ex_rf_we_i = s.we; ex_rf_waddr_i = s.wa; ex_memop_rd_i = s.rd;
      br_taken_i = s.br; dmem_req_i = s.req; dmem_ready_i = s.rdy;
      @(negedge clk);
   endtask

   task automatic do_reset();
      stim_t s = idle();
      s.rsn = 1'b0;
      step(s);
   endtask

   // ---------------- behavioural model (counts owed bubbles) ----------------
   int          owed[2];
   bit          waiting[2];
   logic [31:0] m_stall[2], m_flush[2];
   logic [5:0]  exp_out[2];
   int          n_owed[2];
   bit          n_wait[2];
   logic [31:0] n_stall[2], n_flush[2];

   function automatic int bubbles(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   task automatic model_eval(input stim_t s);
      bit lu, mw, br;
      lu = s.idv && s.exv && s.rd && s.we && (s.wa != 0) && ((s.wa == s.sa) || (s.wa == s.sb));
      mw = s.req && !s.rdy;
      br = s.br && s.exv;
      for (int k = 0; k < 2; k++) begin
         exp_out[k] = OUT_IDLE;
         n_owed[k]  = owed[k];
         n_wait[k]  = waiting[k];
         n_stall[k] = m_stall[k];
         n_flush[k] = m_flush[k];
         if (!s.rsn) begin
            n_owed[k] = 0; n_wait[k] = 0; n_stall[k] = 0; n_flush[k] = 0;
         end else begin
            if (mw) begin
               exp_out[k] = OUT_HOLD;
               if (!waiting[k] && owed[k] == 0 && lu) n_owed[k] = bubbles(k);
               n_wait[k] = 1;
            end else if (br) begin
               exp_out[k] = OUT_FLUSH;
               n_owed[k] = 0; n_wait[k] = 0;
               if (n_flush[k] != 32'hFFFF_FFFF) n_flush[k] = n_flush[k] + 1;
            end else begin
               n_wait[k] = 0;
               if (owed[k] > 0) begin
                  exp_out[k] = OUT_STALL; n_owed[k] = owed[k] - 1;
               end else if (lu && !waiting[k]) begin
                  exp_out[k] = OUT_STALL; n_owed[k] = bubbles(k) - 1;
               end
            end
            if (exp_out[k][4] && n_stall[k] != 32'hFFFF_FFFF) n_stall[k] = n_stall[k] + 1;
         end
      end
   endtask

   task automatic model_commit();
      for (int k = 0; k < 2; k++) begin
         owed[k] = n_owed[k]; waiting[k] = n_wait[k];
         m_stall[k] = n_stall[k]; m_flush[k] = n_flush[k];
      end
   endtask

   // ---------------- directed scenarios ----------------
   task automatic test_reset();
      stim_t s = hazard();
      s.rsn = 1'b0; s.br = 1'b1; s.req = 1'b1;
      step(s);
      n_chk++;
      if (out1 !== OUT_IDLE || out3 !== OUT_IDLE) begin
         n_fail++; $display("FAIL reset_outs got %b/%b exp %b", out1, out3, OUT_IDLE);
      end
      step(idle());
      n_chk++;
      if (stall1 !== 32'd0 || flush1 !== 32'd0 || stall3 !== 32'd0 || flush3 !== 32'd0) begin
         n_fail++; $display("FAIL reset_counters got %0d %0d %0d %0d exp 0", stall1, flush1, stall3, flush3);
      end
      n_chk++;
      if (out1 !== OUT_IDLE) begin
         n_fail++; $display("FAIL reset_idle got %b exp %b", out1, OUT_IDLE);
      end
   endtask

   task automatic test_load_use_default();
      do_reset();
      step(hazard());
      n_chk++;
      if (out1 !== OUT_STALL) begin
         n_fail++; $display("FAIL lu1_c0 got %b exp %b", out1, OUT_STALL);
      end
      step(idle());
      n_chk++;
      if (out1 !== OUT_IDLE) begin
         n_fail++; $display("FAIL lu1_c1 got %b exp %b", out1, OUT_IDLE);
      end
      n_chk++;
      if (stall1 !== 32'd1) begin
         n_fail++; $display("FAIL lu1_stall_cycles got %0d exp 1", stall1);
      end
   endtask

   task automatic test_no_stall();
      stim_t s;
      do_reset();
      s = hazard(); s.wa = 5'd0; s.sa = 5'd0;
      step(s);
      n_chk++;
      if (out1 !== OUT_IDLE || out3 !== OUT_IDLE) begin
         n_fail++; $display("FAIL x0_load got %b/%b exp %b", out1, out3, OUT_IDLE);
      end
      s = hazard(); s.rd = 1'b0; s.sa = 5'd1; s.sb = 5'd5;
      step(s);
      n_chk++;
      if (out1 !== OUT_IDLE || out3 !== OUT_IDLE) begin
         n_fail++; $display("FAIL alu_write got %b/%b exp %b", out1, out3, OUT_IDLE);
      end
   endtask

   task automatic test_load_use_depth3();
      logic [3:0] bid_seen;
      do_reset();
      step(hazard());
      bid_seen[0] = o3_bid;
      n_chk++;
      if (out3 !== OUT_STALL) begin
         n_fail++; $display("FAIL lu3_c0 got %b exp %b", out3, OUT_STALL);
      end
      for (int c = 1; c < 4; c++) begin
         step(idle());
         bid_seen[c] = o3_bid;
      end
      n_chk++;
      if (bid_seen !== 4'b0111) begin
         n_fail++; $display("FAIL lu3_block_id_seq got %b exp 0111", bid_seen);
      end
      n_chk++;
      if (stall3 !== 32'd3) begin
         n_fail++; $display("FAIL lu3_stall_cycles got %0d exp 3", stall3);
      end
   endtask

   task automatic test_lu_mem_wait();
      stim_t s;
      do_reset();
      step(hazard());
      step(memwait());
      n_chk++;
      if (out3 !== OUT_HOLD) begin
         n_fail++; $display("FAIL lumw_c1 got %b exp %b", out3, OUT_HOLD);
      end
      step(memwait());
      n_chk++;
      if (out3 !== OUT_HOLD) begin
         n_fail++; $display("FAIL lumw_c2 got %b exp %b", out3, OUT_HOLD);
      end
      s = idle(); s.req = 1'b1; s.rdy = 1'b1;
      step(s);
      n_chk++;
      if (out3 !== OUT_STALL) begin
         n_fail++; $display("FAIL lumw_resume got %b exp %b", out3, OUT_STALL);
      end
      step(idle());
      n_chk++;
      if (out3 !== OUT_STALL) begin
         n_fail++; $display("FAIL lumw_last_bubble got %b exp %b", out3, OUT_STALL);
      end
      step(idle());
      n_chk++;
      if (out3 !== OUT_IDLE || stall3 !== 32'd5) begin
         n_fail++; $display("FAIL lumw_done got %b stall %0d exp %b stall 5", out3, stall3, OUT_IDLE);
      end
   endtask

   task automatic test_branch_cancels();
      stim_t s;
      do_reset();
      step(hazard());
      s = idle(); s.br = 1'b1; s.exv = 1'b1;
      step(s);
      n_chk++;
      if (out3 !== OUT_FLUSH) begin
         n_fail++; $display("FAIL br_cancel got %b exp %b", out3, OUT_FLUSH);
      end
      step(idle());
      n_chk++;
      if (out3 !== OUT_IDLE || flush3 !== 32'd1 || stall3 !== 32'd1) begin
         n_fail++; $display("FAIL br_after got %b flush %0d stall %0d exp %b flush 1 stall 1",
                            out3, flush3, stall3, OUT_IDLE);
      end
   endtask

   task automatic test_mem_beats_branch();
      stim_t s;
      do_reset();
      s = memwait(); s.br = 1'b1; s.exv = 1'b1;
      step(s);
      n_chk++;
      if (out1 !== OUT_HOLD || out3 !== OUT_HOLD) begin
         n_fail++; $display("FAIL mw_vs_br got %b/%b exp %b", out1, out3, OUT_HOLD);
      end
      step(idle());
      n_chk++;
      if (out1 !== OUT_IDLE || flush1 !== 32'd0 || flush3 !== 32'd0) begin
         n_fail++; $display("FAIL mw_vs_br_after got %b flush %0d/%0d exp %b flush 0",
                            out1, flush1, flush3, OUT_IDLE);
      end
   endtask

   task automatic test_reset_mid_stall();
      stim_t s;
      do_reset();
      step(hazard());
      step(memwait());
      s = memwait(); s.rsn = 1'b0;
      step(s);
      n_chk++;
      if (out3 !== OUT_IDLE || out1 !== OUT_IDLE) begin
         n_fail++; $display("FAIL rst_mid_outs got %b/%b exp %b", out1, out3, OUT_IDLE);
      end
      step(hazard());
      n_chk++;
      if (out3 !== OUT_STALL || stall3 !== 32'd0 || flush3 !== 32'd0) begin
         n_fail++; $display("FAIL rst_mid_run got %b stall %0d flush %0d exp %b 0 0",
                            out3, stall3, flush3, OUT_STALL);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      step(idle());
      d1.u_stall_cnt.cnt_q = 32'hFFFF_FFFF;
      step(hazard());
      n_chk++;
      if (o1_bid !== 1'b1 || stall1 !== 32'hFFFF_FFFF) begin
         n_fail++; $display("FAIL sat_pre got bid %b cnt %h exp 1 ffffffff", o1_bid, stall1);
      end
      step(idle());
      n_chk++;
      if (stall1 !== 32'hFFFF_FFFF) begin
         n_fail++; $display("FAIL sat_hold got %h exp ffffffff", stall1);
      end
   endtask

   task automatic test_random();
      stim_t s;
      do_reset();
      for (int k = 0; k < 2; k++) begin
         owed[k] = 0; waiting[k] = 0; m_stall[k] = '0; m_flush[k] = '0;
      end
      for (int c = 0; c < 800; c++) begin
         s.rsn = ($urandom_range(0, 39) != 0);
         s.idv = ($urandom_range(0, 3) != 0);
         s.sa  = 5'($urandom_range(0, 3));
         s.sb  = 5'($urandom_range(0, 3));
         s.exv = ($urandom_range(0, 3) != 0);
         s.we  = ($urandom_range(0, 3) != 0);
         s.wa  = 5'($urandom_range(0, 3));
         s.rd  = ($urandom_range(0, 1) != 0);
         s.br  = ($urandom_range(0, 9) == 0);
         s.req = ($urandom_range(0, 2) == 0);
         s.rdy = ($urandom_range(0, 1) != 0);
         step(s);
         model_eval(s);
         n_chk++;
         if (out1 !== exp_out[0] || out3 !== exp_out[1]) begin
            n_fail++; $display("FAIL rand_outs cyc %0d got %b/%b exp %b/%b",
                               c, out1, out3, exp_out[0], exp_out[1]);
         end
         n_chk++;
         if (stall1 !== m_stall[0] || flush1 !== m_flush[0] ||
             stall3 !== m_stall[1] || flush3 !== m_flush[1]) begin
            n_fail++; $display("FAIL rand_cnts cyc %0d got %0d %0d %0d %0d exp %0d %0d %0d %0d",
                               c, stall1, flush1, stall3, flush3,
                               m_stall[0], m_flush[0], m_stall[1], m_flush[1]);
         end
         model_commit();
      end
   endtask

   initial begin
      test_reset();
      test_load_use_default();
      test_no_stall();
      test_load_use_depth3();
      test_lu_mem_wait();
      test_branch_cancels();
      test_mem_beats_branch();
      test_reset_mid_stall();
      test_saturation();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
